// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions.
//   word_t        : 32-bit data/address word
//   dcache_addr_t : dcache view of an address (tag / set index / block word / byte offset)
//   msi_t         : MSI coherence state of a cache frame
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef struct packed {
        logic [25:0] tag;
        logic [2:0]  idx;
        logic        blkoff;
        logic [1:0]  byteoff;
    } dcache_addr_t;

    typedef enum logic [1:0] {
        I = 2'd0,
        S = 2'd1,
        M = 2'd2
    } msi_t;

endpackage

// File: rtl/dcache_snoop_responder_if.sv
// Snoop and data-port signals between the memory controller and one dcache.
//   master : memory controller side (issues snoops, paces write-back words with dwait)
//   slave  : dcache snoop responder (answers with cctrans and the write-back words)
interface dcache_snoop_responder_if;
    import cpu_types_pkg::*;

    logic  ccwait;
    logic  ccinv;
    word_t ccsnoopaddr;
    logic  dwait;
    logic  cctrans;
    logic  dWEN;
    word_t daddr;
    word_t dstore;

    modport master (
        output ccwait, ccinv, ccsnoopaddr, dwait,
        input  cctrans, dWEN, daddr, dstore
    );

    modport slave (
        input  ccwait, ccinv, ccsnoopaddr, dwait,
        output cctrans, dWEN, daddr, dstore
    );

endinterface

// File: rtl/snoop_tag_match.sv
// Combinational tag compare across the ways of one set.
//   tag       : snooped tag
//   lk_tag    : tags of the indexed set
//   lk_state  : MSI states of the indexed set
//   hit       : some valid way holds the tag
//   way       : lowest matching way
//   state     : MSI state of that way
//   multi_hit : more than one way matched (coherence protocol error)
module snoop_tag_match
    import cpu_types_pkg::*;
#(
    parameter int WAYS = 2,
    parameter int TAGW = 26,
    localparam int WAYW = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic [TAGW-1:0]            tag,
    input  logic [WAYS-1:0][TAGW-1:0]  lk_tag,
    input  logic [WAYS-1:0][1:0]       lk_state,
    output logic                       hit,
    output logic [WAYW-1:0]            way,
    output msi_t                       state,
    output logic                       multi_hit
);

    always_comb begin
        hit       = 1'b0;
        way       = '0;
        state     = I;
        multi_hit = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (lk_state[w] != I && lk_tag[w] == tag) begin
                if (hit) begin
                    multi_hit = 1'b1;
                end else begin
                    hit   = 1'b1;
                    way   = WAYW'(w);
                    state = msi_t'(lk_state[w]);
                end
            end
        end
    end

endmodule

// File: rtl/dcache_snoop_responder.sv
// Coherence snoop responder for one core's dcache (MSI).
// Looks the snooped block up in the frame array, writes a Modified block back word by word
// over the data port (for cache-to-cache forwarding) and downgrades/invalidates the frame.
//   CLK, nRST        : clock, asynchronous active-low reset
//   bus (slave)      : ccwait/ccinv/ccsnoopaddr in, dwait in, cctrans/dWEN/daddr/dstore out
//   lk_idx           : frame-array lookup index
//   lk_tag, lk_state : tags and MSI states of the indexed set
//   rd_way, rd_blk   : data-array read select; rd_data is the zero-latency read word
//   upd_en/way/state : one-cycle frame state write
//   snoop_busy       : the dcache miss/write-back FSM must yield the array and data port
module dcache_snoop_responder
    import cpu_types_pkg::*;
#(
    parameter int SETS = 8,
    parameter int WAYS = 2,
    parameter int TAGW = 26,
    localparam int IDXW = $clog2(SETS),
    localparam int WAYW = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic                       CLK,
    input  logic                       nRST,
    dcache_snoop_responder_if.slave    bus,
    output logic [IDXW-1:0]            lk_idx,
    input  logic [WAYS-1:0][TAGW-1:0]  lk_tag,
    input  logic [WAYS-1:0][1:0]       lk_state,
    output logic [WAYW-1:0]            rd_way,
    output logic                       rd_blk,
    input  word_t                      rd_data,
    output logic                       upd_en,
    output logic [WAYW-1:0]            upd_way,
    output msi_t                       upd_state,
    output logic                       snoop_busy
);

    typedef enum logic [2:0] {IDLE, CHECK, WB0, WB1, DONE} state_t;

    state_t          state;
    dcache_addr_t    saddr;
    logic            sinv;
    logic [WAYW-1:0] hit_way;

    logic            hit;
    logic [WAYW-1:0] match_way;
    msi_t            match_state;
    logic            multi_hit;
    logic            in_wb;
    logic            unused_addr_bits;

    snoop_tag_match #(
        .WAYS (WAYS),
        .TAGW (TAGW)
    ) u_tag_match (
        .tag       (TAGW'(saddr.tag)),
        .lk_tag    (lk_tag),
        .lk_state  (lk_state),
        .hit       (hit),
        .way       (match_way),
        .state     (match_state),
        .multi_hit (multi_hit)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            saddr     <= '0;
            sinv      <= 1'b0;
            hit_way   <= '0;
            upd_en    <= 1'b0;
            upd_way   <= '0;
            upd_state <= I;
        end else begin
            upd_en <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.ccwait) begin
                        saddr <= dcache_addr_t'(bus.ccsnoopaddr);
                        sinv  <= bus.ccinv;
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (!bus.ccwait) begin
                        state <= IDLE;
                    end else if (hit && match_state == M) begin
                        hit_way <= match_way;
                        state   <= WB0;
                    end else if (hit && match_state == S && sinv) begin
                        upd_en    <= 1'b1;
                        upd_way   <= match_way;
                        upd_state <= I;
                        state     <= DONE;
                    end else begin
                        state <= DONE;
                    end
                end
                WB0: begin
                    if (!bus.dwait) state <= WB1;
                end
                WB1: begin
                    // ccwait is not consulted here: a started write-back always completes
                    if (!bus.dwait) begin
                        upd_en    <= 1'b1;
                        upd_way   <= hit_way;
                        upd_state <= sinv ? I : S;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // Hold until the controller withdraws the snoop: one response per snoop
                    if (!bus.ccwait) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Bus outputs decode the state register only, so they hold steady while dwait stalls
    assign in_wb       = (state == WB0) || (state == WB1);
    assign bus.cctrans = in_wb;
    assign bus.dWEN    = in_wb;
    assign bus.daddr   = in_wb ? {saddr[31:3], (state == WB1), 2'b00} : '0;
    assign bus.dstore  = in_wb ? rd_data : '0;

    assign lk_idx     = IDXW'(saddr.idx);
    assign rd_way     = hit_way;
    assign rd_blk     = (state == WB1);
    assign snoop_busy = (state != IDLE) || bus.ccwait;

    assign unused_addr_bits = ^{saddr.blkoff, saddr.byteoff};

    // Two valid copies of one block in a set break the MSI invariant
    assert property (@(posedge CLK) disable iff (!nRST) (state == CHECK) |-> !multi_hit);

endmodule

// File: tb/tb_dcache_snoop_responder.sv
// Bench for dcache_snoop_responder: frame array model, directed scenarios and random snoops
// checked against a reference computed from the MSI snoop rules.
module tb_dcache_snoop_responder;

    logic             CLK = 1'b0;
    logic             nRST;
    logic [2:0]       lk_idx;
    logic [1:0][25:0] lk_tag;
    logic [1:0][1:0]  lk_state;
    logic             rd_way;
    logic             rd_blk;
    logic [31:0]      rd_data;
    logic             upd_en;
    logic             upd_way;
    logic [1:0]       upd_state;
    logic             snoop_busy;

    dcache_snoop_responder_if bus ();

    dcache_snoop_responder #(
        .SETS (8),
        .WAYS (2),
        .TAGW (26)
    ) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .bus        (bus),
        .lk_idx     (lk_idx),
        .lk_tag     (lk_tag),
        .lk_state   (lk_state),
        .rd_way     (rd_way),
        .rd_blk     (rd_blk),
        .rd_data    (rd_data),
        .upd_en     (upd_en),
        .upd_way    (upd_way),
        .upd_state  (upd_state),
        .snoop_busy (snoop_busy)
    );

    always #5 CLK = ~CLK;

    // Frame array: tags, MSI states, two data words per frame
    logic [25:0] ftag [8][2];
    logic [1:0]  fst  [8][2];
    logic [31:0] fdat [8][2][2];

    always_comb begin
        for (int w = 0; w < 2; w++) begin
            lk_tag[w]   = ftag[lk_idx][w];
            lk_state[w] = fst[lk_idx][w];
        end
        rd_data = fdat[lk_idx][rd_way][rd_blk];
    end

    int vectors = 0;
    int miscompares = 0;

    // Observations from the last snoop
    int          obs_nwords;
    logic [31:0] obs_addr [2];
    logic [31:0] obs_data [2];
    int          obs_first_dwen;
    int          obs_upd_cnt;
    int          obs_first_upd;
    logic        obs_upd_way;
    logic [1:0]  obs_upd_state;
    int          obs_cct_bad;
    logic        obs_busy_after;

    // Reference: lowest valid way holding the tag, or -1 on a miss
    task automatic model(input logic [31:0] a, output int hw, output logic [1:0] hs);
        hw = -1;
        hs = 2'd0;
        for (int w = 0; w < 2; w++) begin
            if (hw < 0 && fst[a[5:3]][w] != 2'd0 && ftag[a[5:3]][w] == a[31:6]) begin
                hw = w;
                hs = fst[a[5:3]][w];
            end
        end
    endtask

    // Issue one snoop, pace write-back words with w wait cycles each, withdraw after hold cycles
    task automatic run_snoop(input logic [31:0] a, input logic inv, input int w, input int hold);
        int wcnt;
        wcnt = w;
        obs_nwords = 0; obs_first_dwen = -1; obs_upd_cnt = 0; obs_first_upd = -1;
        obs_upd_way = 1'b0; obs_upd_state = 2'd0; obs_cct_bad = 0; obs_busy_after = 1'b1;
        obs_addr[0] = '0; obs_addr[1] = '0; obs_data[0] = '0; obs_data[1] = '0;
        @(negedge CLK);
        bus.ccwait = 1'b1; bus.ccsnoopaddr = a; bus.ccinv = inv; bus.dwait = 1'b1;
        for (int c = 1; c <= hold + 3; c++) begin
            @(negedge CLK);
            if (c == 1) begin
                bus.ccsnoopaddr = $urandom;
                bus.ccinv = 1'($urandom);
            end
            if (bus.cctrans !== bus.dWEN) obs_cct_bad++;
            if (upd_en === 1'b1) begin
                if (obs_upd_cnt == 0) begin
                    obs_first_upd = c; obs_upd_way = upd_way; obs_upd_state = upd_state;
                end
                obs_upd_cnt++;
                fst[a[5:3]][upd_way] = upd_state;
            end
            if (bus.dWEN === 1'b1) begin
                if (obs_first_dwen < 0) obs_first_dwen = c;
                if (wcnt > 0) begin
                    bus.dwait = 1'b1;
                    wcnt--;
                end else begin
                    bus.dwait = 1'b0;
                    if (obs_nwords < 2) begin
                        obs_addr[obs_nwords] = bus.daddr;
                        obs_data[obs_nwords] = bus.dstore;
                    end
                    obs_nwords++;
                    wcnt = w;
                end
            end else begin
                bus.dwait = 1'b1;
            end
            if (c == hold) bus.ccwait = 1'b0;
            if (c == hold + 1) obs_busy_after = snoop_busy;
        end
        bus.dwait = 1'b1; bus.ccinv = 1'b0; bus.ccsnoopaddr = '0;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        #3;
        vectors++;
        if ({bus.dWEN, bus.cctrans, upd_en, upd_state, lk_idx, snoop_busy} !== 9'd0 ||
            bus.daddr !== 32'd0 || bus.dstore !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: dWEN=%b cctrans=%b upd_en=%b daddr=%h dstore=%h busy=%b, want all 0",
                     bus.dWEN, bus.cctrans, upd_en, bus.daddr, bus.dstore, snoop_busy);
        end
        bus.ccwait = 1'b1;
        #1;
        vectors++;
        if (snoop_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_busy_follows_ccwait: got %b want 1", snoop_busy);
        end
        bus.ccwait = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_miss();
        fst[3][0] = 2'd0; fst[3][1] = 2'd0;
        ftag[3][0] = 26'h1; ftag[3][1] = 26'h1;
        run_snoop(32'h0000_0058, 1'b1, 0, 6);
        vectors++;
        if (obs_first_dwen != -1 || obs_upd_cnt != 0 || obs_busy_after !== 1'b0) begin
            miscompares++;
            $display("FAIL miss: first_dwen=%0d upd_cnt=%0d busy_after=%b want -1 0 0",
                     obs_first_dwen, obs_upd_cnt, obs_busy_after);
        end
    endtask

    task automatic test_s_hit();
        ftag[0][0] = 26'h7; fst[0][0] = 2'd2;
        ftag[0][1] = 26'h5; fst[0][1] = 2'd1;
        run_snoop(32'h0000_0140, 1'b0, 0, 6);
        vectors++;
        if (obs_first_dwen != -1 || obs_upd_cnt != 0 || obs_cct_bad != 0) begin
            miscompares++;
            $display("FAIL s_hit_read: first_dwen=%0d upd_cnt=%0d cct_bad=%0d want -1 0 0",
                     obs_first_dwen, obs_upd_cnt, obs_cct_bad);
        end
        run_snoop(32'h0000_0140, 1'b1, 0, 6);
        vectors++;
        if (obs_upd_cnt != 1 || obs_upd_way !== 1'b1 || obs_upd_state !== 2'd0 ||
            obs_first_upd != 2 || obs_first_dwen != -1) begin
            miscompares++;
            $display("FAIL s_hit_inv: upd_cnt=%0d way=%b state=%0d at=%0d dwen=%0d want 1 1 0 2 -1",
                     obs_upd_cnt, obs_upd_way, obs_upd_state, obs_first_upd, obs_first_dwen);
        end
    endtask

    task automatic test_m_hit(input logic inv);
        ftag[0][0] = 26'h1; fst[0][0] = 2'd2;
        ftag[0][1] = 26'h3ff; fst[0][1] = 2'd1;
        fdat[0][0][0] = 32'hDEAD_BEEF; fdat[0][0][1] = 32'hCAFE_F00D;
        run_snoop(32'h0000_0040, inv, 3, 14);
        vectors++;
        if (obs_nwords != 2 || obs_addr[0] !== 32'h40 || obs_addr[1] !== 32'h44 ||
            obs_data[0] !== 32'hDEAD_BEEF || obs_data[1] !== 32'hCAFE_F00D) begin
            miscompares++;
            $display("FAIL m_hit_words: n=%0d %h:%h %h:%h want 2 40:deadbeef 44:cafef00d",
                     obs_nwords, obs_addr[0], obs_data[0], obs_addr[1], obs_data[1]);
        end
        vectors++;
        if (obs_cct_bad != 0 || obs_first_dwen != 2) begin
            miscompares++;
            $display("FAIL m_hit_cctrans: cct_bad=%0d first_dwen=%0d want 0 2",
                     obs_cct_bad, obs_first_dwen);
        end
        vectors++;
        if (obs_upd_cnt != 1 || obs_upd_way !== 1'b0 || obs_upd_state !== (inv ? 2'd0 : 2'd1) ||
            obs_first_upd != 10 || obs_busy_after !== 1'b0) begin
            miscompares++;
            $display("FAIL m_hit_update inv=%b: cnt=%0d way=%b state=%0d at=%0d busy=%b want 1 0 %0d 10 0",
                     inv, obs_upd_cnt, obs_upd_way, obs_upd_state, obs_first_upd,
                     obs_busy_after, inv ? 0 : 1);
        end
    endtask

    task automatic test_withdraw();
        ftag[0][0] = 26'h1; fst[0][0] = 2'd2;
        @(negedge CLK);
        bus.ccwait = 1'b1; bus.ccsnoopaddr = 32'h40; bus.ccinv = 1'b0; bus.dwait = 1'b1;
        @(negedge CLK);
        bus.ccwait = 1'b0;
        for (int c = 2; c <= 4; c++) begin
            @(negedge CLK);
            vectors++;
            if (snoop_busy !== 1'b0 || bus.dWEN !== 1'b0 || bus.cctrans !== 1'b0 ||
                upd_en !== 1'b0) begin
                miscompares++;
                $display("FAIL withdraw c%0d: busy=%b dWEN=%b cctrans=%b upd_en=%b want 0 0 0 0",
                         c, snoop_busy, bus.dWEN, bus.cctrans, upd_en);
            end
        end
    endtask

    task automatic test_reset_mid_wb();
        ftag[0][0] = 26'h1; fst[0][0] = 2'd2;
        fdat[0][0][0] = 32'h1111_2222; fdat[0][0][1] = 32'h3333_4444;
        @(negedge CLK);
        bus.ccwait = 1'b1; bus.ccsnoopaddr = 32'h40; bus.ccinv = 1'b0; bus.dwait = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        bus.dwait = 1'b0;
        @(negedge CLK);
        bus.dwait = 1'b1;
        vectors++;
        if (bus.dWEN !== 1'b1 || bus.daddr !== 32'h44 || bus.dstore !== 32'h3333_4444) begin
            miscompares++;
            $display("FAIL rst_wb1_reached: dWEN=%b daddr=%h dstore=%h want 1 44 33334444",
                     bus.dWEN, bus.daddr, bus.dstore);
        end
        #2 nRST = 1'b0;
        #1;
        vectors++;
        if (bus.dWEN !== 1'b0 || bus.cctrans !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_async_drop: dWEN=%b cctrans=%b want 0 0", bus.dWEN, bus.cctrans);
        end
        bus.ccwait = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
        vectors++;
        if (snoop_busy !== 1'b0 || upd_en !== 1'b0 || fst[0][0] !== 2'd2) begin
            miscompares++;
            $display("FAIL rst_idle: busy=%b upd_en=%b frame_state=%0d want 0 0 2",
                     snoop_busy, upd_en, fst[0][0]);
        end
        run_snoop(32'h0000_0040, 1'b0, 0, 8);
        vectors++;
        if (obs_nwords != 2 || obs_data[0] !== 32'h1111_2222 || obs_data[1] !== 32'h3333_4444 ||
            obs_upd_cnt != 1 || obs_upd_state !== 2'd1 || obs_first_upd != 4) begin
            miscompares++;
            $display("FAIL rst_resnoop: n=%0d d0=%h d1=%h upd=%0d st=%0d at=%0d want 2 11112222 33334444 1 1 4",
                     obs_nwords, obs_data[0], obs_data[1], obs_upd_cnt, obs_upd_state,
                     obs_first_upd);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            logic [2:0]  s;
            logic [25:0] t;
            logic [31:0] a;
            logic        inv;
            int          w;
            int          hw;
            logic [1:0]  hs;
            logic        exp_wb;
            logic        exp_upd;
            s = 3'($urandom);
            ftag[s][0] = 26'($urandom);
            ftag[s][1] = ftag[s][0] ^ 26'($urandom_range(1, 26'h3ff_ffff));
            for (int k = 0; k < 2; k++) begin
                fst[s][k] = 2'($urandom_range(0, 2));
                fdat[s][k][0] = $urandom;
                fdat[s][k][1] = $urandom;
            end
            t = ($urandom_range(0, 3) != 0) ? ftag[s][$urandom_range(0, 1)] : 26'($urandom);
            a = {t, s, 3'($urandom)};
            inv = 1'($urandom);
            w = $urandom_range(0, 3);
            model(a, hw, hs);
            exp_wb = (hw >= 0 && hs == 2'd2);
            exp_upd = exp_wb || (hw >= 0 && hs == 2'd1 && inv);
            run_snoop(a, inv, w, 6 + 2 * w);
            vectors++;
            if (obs_nwords != (exp_wb ? 2 : 0) || obs_cct_bad != 0 ||
                obs_first_dwen != (exp_wb ? 2 : -1) || obs_busy_after !== 1'b0) begin
                miscompares++;
                $display("FAIL rand%0d_bus a=%h: n=%0d dwen_at=%0d cct_bad=%0d busy=%b want n=%0d",
                         n, a, obs_nwords, obs_first_dwen, obs_cct_bad, obs_busy_after,
                         exp_wb ? 2 : 0);
            end
            if (exp_wb) begin
                vectors++;
                if (obs_addr[0] !== {a[31:3], 3'b000} || obs_addr[1] !== {a[31:3], 3'b100} ||
                    obs_data[0] !== fdat[s][hw][0] || obs_data[1] !== fdat[s][hw][1]) begin
                    miscompares++;
                    $display("FAIL rand%0d_data: %h:%h %h:%h want %h:%h %h:%h", n,
                             obs_addr[0], obs_data[0], obs_addr[1], obs_data[1],
                             {a[31:3], 3'b000}, fdat[s][hw][0], {a[31:3], 3'b100},
                             fdat[s][hw][1]);
                end
            end
            vectors++;
            if (obs_upd_cnt != (exp_upd ? 1 : 0) ||
                (exp_upd && (obs_upd_way !== 1'(hw) ||
                             obs_upd_state !== ((inv || !exp_wb) ? 2'd0 : 2'd1) ||
                             obs_first_upd != (exp_wb ? 4 + 2 * w : 2)))) begin
                miscompares++;
                $display("FAIL rand%0d_upd a=%h inv=%b: cnt=%0d way=%b st=%0d at=%0d want cnt=%0d way=%0d",
                         n, a, inv, obs_upd_cnt, obs_upd_way, obs_upd_state, obs_first_upd,
                         exp_upd ? 1 : 0, hw);
            end
        end
    endtask

    initial begin
        bus.ccwait = 1'b0; bus.ccinv = 1'b0; bus.ccsnoopaddr = '0; bus.dwait = 1'b1;
        for (int s = 0; s < 8; s++) begin
            for (int k = 0; k < 2; k++) begin
                ftag[s][k] = 26'($urandom);
                fst[s][k] = 2'd0;
                fdat[s][k][0] = $urandom;
                fdat[s][k][1] = $urandom;
            end
        end
        test_reset();
        test_miss();
        test_s_hit();
        test_m_hit(1'b0);
        test_m_hit(1'b1);
        test_withdraw();
        test_reset_mid_wb();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
